// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory for the cache ports: one burst at a time,
// single-port word RAM with byte enables, registered R channel.
module axi4_mem_responder #(
  parameter int          MEM_ADDR_W = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o
);

  localparam int DEPTH = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ
  } state_e;

  typedef logic [MEM_ADDR_W-1:0] idx_t;

  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:MEM_ADDR_W+2] == BASE_ADDR[31:MEM_ADDR_W+2];
  endfunction

  function automatic idx_t adv_idx(
    input idx_t       idx,
    input logic [7:0] len,
    input logic [1:0] burst
  );
    idx_t inc;
    idx_t mask;
    logic wrap_ok;
    inc     = idx + MEM_ADDR_W'(1);
    mask    = MEM_ADDR_W'(len);
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    if (burst == 2'd0) begin
      return idx;
    end else if (burst == 2'd2 && wrap_ok) begin
      return (idx & ~mask) | (inc & mask);
    end
    return inc;
  endfunction

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic       err_q, err_d;
  logic       hit_q, hit_d;
  idx_t       idx_q, idx_d;
  logic [3:0] id_q, id_d;
  logic [7:0] len_q, len_d;
  logic [1:0] burst_q, burst_d;
  logic [7:0] cnt_q, cnt_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  idx_t        ram_addr;
  logic        ram_we;
  logic        ram_re;
  logic        ram_rzero;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;

  logic aw_gnt;
  logic ar_gnt;
  logic last_beat;
  idx_t nxt_idx;

  logic unused_ok;
  assign unused_ok = ^{axi_awaddr_i[1:0], axi_araddr_i[1:0]};

  assign last_beat = (cnt_q == len_q);
  assign nxt_idx   = adv_idx(idx_q, len_q, burst_q);

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    err_d     = err_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    ram_addr  = idx_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_rzero = !hit_q;
    ram_be    = axi_wstrb_i;
    ram_wdata = axi_wdata_i;
    aw_gnt    = 1'b0;
    ar_gnt    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ar_gnt = axi_arvalid_i && (!axi_awvalid_i || prio_q);
        aw_gnt = axi_awvalid_i && (!axi_arvalid_i || !prio_q);
        if (ar_gnt) begin
          prio_d    = !prio_q;
          hit_d     = addr_hit(axi_araddr_i);
          idx_d     = axi_araddr_i[MEM_ADDR_W+1:2];
          id_d      = axi_arid_i;
          len_d     = axi_arlen_i;
          burst_d   = axi_arburst_i;
          cnt_d     = 8'd0;
          ram_addr  = axi_araddr_i[MEM_ADDR_W+1:2];
          ram_re    = 1'b1;
          ram_rzero = !addr_hit(axi_araddr_i);
          state_d   = S_READ;
        end else if (aw_gnt) begin
          prio_d  = !prio_q;
          hit_d   = addr_hit(axi_awaddr_i);
          idx_d   = axi_awaddr_i[MEM_ADDR_W+1:2];
          id_d    = axi_awid_i;
          len_d   = axi_awlen_i;
          burst_d = axi_awburst_i;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (axi_wvalid_i) begin
          ram_we = hit_q;
          idx_d  = nxt_idx;
          cnt_d  = cnt_q + 8'd1;
          if (axi_wlast_i != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        if (axi_bready_i) begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (axi_rready_i) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            idx_d    = nxt_idx;
            cnt_d    = cnt_q + 8'd1;
            ram_addr = nxt_idx;
            ram_re   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // reset abandons the burst: no grants, no RAM side effects
    if (rst_i) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
      aw_gnt = 1'b0;
      ar_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b1;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      id_q    <= 4'd0;
      len_q   <= 8'd0;
      burst_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && ram_be[b]) begin
        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_re) begin
      rdata_q <= ram_rzero ? 32'd0 : mem[ram_addr];
    end
  end

  assign axi_awready_o = aw_gnt;
  assign axi_arready_o = ar_gnt;
  assign axi_wready_o  = !rst_i && (state_q == S_WRITE);
  assign axi_bvalid_o  = !rst_i && (state_q == S_WRESP);
  assign axi_rvalid_o  = !rst_i && (state_q == S_READ);

  assign axi_bresp_o = !axi_bvalid_o ? 2'b00 :
                       !hit_q        ? 2'b11 :
                       err_q         ? 2'b10 : 2'b00;
  assign axi_bid_o   = axi_bvalid_o ? id_q : 4'd0;

  assign axi_rdata_o = axi_rvalid_o ? rdata_q : 32'd0;
  assign axi_rresp_o = (axi_rvalid_o && !hit_q) ? 2'b11 : 2'b00;
  assign axi_rid_o   = axi_rvalid_o ? id_q : 4'd0;
  assign axi_rlast_o = axi_rvalid_o && last_beat;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: bursts, strobes, wrap,
// decode miss, wlast error, arbitration, backpressure, reset.
module tb_axi4_mem_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [31:0] ex [16];

  always #5 clk = ~clk;

  axi4_mem_responder dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .axi_awvalid_i (awvalid),
    .axi_awready_o (awready),
    .axi_awaddr_i  (awaddr),
    .axi_awid_i    (awid),
    .axi_awlen_i   (awlen),
    .axi_awburst_i (awburst),
    .axi_wvalid_i  (wvalid),
    .axi_wready_o  (wready),
    .axi_wdata_i   (wdata),
    .axi_wstrb_i   (wstrb),
    .axi_wlast_i   (wlast),
    .axi_bvalid_o  (bvalid),
    .axi_bready_i  (bready),
    .axi_bresp_o   (bresp),
    .axi_bid_o     (bid),
    .axi_arvalid_i (arvalid),
    .axi_arready_o (arready),
    .axi_araddr_i  (araddr),
    .axi_arid_i    (arid),
    .axi_arlen_i   (arlen),
    .axi_arburst_i (arburst),
    .axi_rvalid_o  (rvalid),
    .axi_rready_i  (rready),
    .axi_rdata_o   (rdata),
    .axi_rresp_o   (rresp),
    .axi_rid_o     (rid),
    .axi_rlast_o   (rlast)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] strb, input logic badlast,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    awaddr  = addr;
    awid    = id;
    awlen   = len;
    awburst = burst;
    awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".awready"}, awready, 1);
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = wd[i];
      wstrb  = strb;
      wlast  = badlast ? (i == 0) : (i == int'(len));
      #1;
      chk({tag, ".wready"}, wready, 1);
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b0;
    #1;
    chk({tag, ".bvalid"}, bvalid, 1);
    chk({tag, ".bresp"}, bresp, exp_resp);
    chk({tag, ".bid"}, bid, id);
    step();
    chk({tag, ".bvalid_hold"}, bvalid, 1);
    chk({tag, ".bresp_hold"}, bresp, exp_resp);
    bready = 1'b1;
    step();
    bready = 1'b0;
    #1;
    chk({tag, ".bvalid_done"}, bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst,
                         input logic [1:0] exp_resp, input logic toggle,
                         input string tag);
    int n;
    araddr  = addr;
    arid    = id;
    arlen   = len;
    arburst = burst;
    arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".arready"}, arready, 1);
    step();
    arvalid = 1'b0;
    rready  = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (toggle && i == 1) begin
        #1;
        chk({tag, ".stall_rvalid"}, rvalid, 1);
        chk({tag, ".stall_rdata0"}, rdata, ex[i]);
        step();
        chk({tag, ".stall_rdata1"}, rdata, ex[i]);
      end
      rready = 1'b1;
      #1;
      chk({tag, ".rvalid"}, rvalid, 1);
      chk({tag, ".rdata"}, rdata, ex[i]);
      chk({tag, ".rlast"}, rlast, (i == int'(len)) ? 1 : 0);
      chk({tag, ".rresp"}, rresp, exp_resp);
      chk({tag, ".rid"}, rid, id);
      step();
      rready = 1'b0;
    end
    #1;
    chk({tag, ".rvalid_done"}, rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i   = 1'b1;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awburst = '0;
    wvalid  = 1'b0; wdata  = '0; wstrb = '0; wlast = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arburst = '0;
    rready  = 1'b0;
    step();
    step();

    // both channels requested while still in reset
    araddr  = 32'h0000_1000; arid = 4'd3; arlen = 8'd0; arburst = 2'd1;
    awaddr  = 32'h8000_0010; awid = 4'd5; awlen = 8'd3; awburst = 2'd1;
    arvalid = 1'b1;
    awvalid = 1'b1;
    #1;
    chk("rst.awready", awready, 0);
    chk("rst.arready", arready, 0);
    chk("rst.wready", wready, 0);
    chk("rst.bvalid", bvalid, 0);
    chk("rst.rvalid", rvalid, 0);
    step();
    rst_i = 1'b0;
    #1;
    chk("arb.arready_first", arready, 1);
    chk("arb.awready_first", awready, 0);
    step();
    arvalid = 1'b0;
    #1;
    chk("arb.awready_busy", awready, 0);
    chk("miss_rd0.rvalid", rvalid, 1);
    chk("miss_rd0.rdata", rdata, 0);
    chk("miss_rd0.rresp", rresp, 2'b11);
    chk("miss_rd0.rid", rid, 4'd3);
    chk("miss_rd0.rlast", rlast, 1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    #1;
    chk("arb.rvalid_done", rvalid, 0);
    chk("arb.awready_second", awready, 1);

    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    do_write(32'h8000_0010, 4'd5, 8'd3, 2'd1, 4'hF, 1'b0, 2'b00, "incr_wr");
    ex[0] = 32'h11; ex[1] = 32'h22; ex[2] = 32'h33; ex[3] = 32'h44;
    do_read(32'h8000_0010, 4'd6, 8'd3, 2'd1, 2'b00, 1'b1, "incr_rd");

    wd[0] = 32'hA1; wd[1] = 32'hB2;
    do_write(32'h8000_0200, 4'd7, 8'd1, 2'd1, 4'hF, 1'b1, 2'b10, "wlast");
    ex[0] = 32'hA1; ex[1] = 32'hB2;
    do_read(32'h8000_0200, 4'd7, 8'd1, 2'd1, 2'b00, 1'b0, "wlast_rd");

    wd[0] = 32'h0;
    do_write(32'h8000_0100, 4'd1, 8'd0, 2'd1, 4'hF, 1'b0, 2'b00, "zero_wr");
    wd[0] = 32'hAABB_CCDD;
    do_write(32'h8000_0100, 4'd1, 8'd0, 2'd1, 4'h5, 1'b0, 2'b00, "strb_wr");
    ex[0] = 32'h00BB_00DD;
    do_read(32'h8000_0100, 4'd1, 8'd0, 2'd1, 2'b00, 1'b0, "strb_rd");

    for (int i = 0; i < 8; i++) wd[i] = i;
    do_write(32'h8000_0000, 4'd2, 8'd7, 2'd1, 4'hF, 1'b0, 2'b00, "fill");
    ex[0] = 32'd6; ex[1] = 32'd7; ex[2] = 32'd4; ex[3] = 32'd5;
    do_read(32'h8000_0018, 4'd2, 8'd3, 2'd2, 2'b00, 1'b0, "wrap_rd");
    ex[0] = 32'd3; ex[1] = 32'd3; ex[2] = 32'd3;
    do_read(32'h8000_000C, 4'd4, 8'd2, 2'd0, 2'b00, 1'b0, "fixed_rd");

    wd[0] = 32'h1234_5678;
    do_write(32'h8000_1000, 4'd8, 8'd0, 2'd1, 4'hF, 1'b0, 2'b00, "pre_wr");
    wd[0] = 32'hDEAD_BEEF;
    do_write(32'h0000_1000, 4'd9, 8'd0, 2'd1, 4'hF, 1'b0, 2'b11, "miss_wr");
    ex[0] = 32'h1234_5678;
    do_read(32'h8000_1000, 4'd8, 8'd0, 2'd1, 2'b00, 1'b0, "miss_keep");
    ex[0] = 32'h0;
    do_read(32'h0000_1000, 4'd9, 8'd0, 2'd1, 2'b11, 1'b0, "miss_rd");

    // reset in the middle of a 4-beat read
    araddr  = 32'h8000_0000; arid = 4'd1; arlen = 8'd3; arburst = 2'd1;
    arvalid = 1'b1;
    #1;
    chk("mid.arready", arready, 1);
    step();
    arvalid = 1'b0;
    rready  = 1'b1;
    #1;
    chk("mid.beat0", rdata, 32'd0);
    step();
    rready  = 1'b0;
    rst_i   = 1'b1;
    araddr  = 32'h8000_0004; arlen = 8'd0;
    arvalid = 1'b1;
    #1;
    chk("mid.rst_rvalid", rvalid, 0);
    chk("mid.rst_arready", arready, 0);
    step();
    rst_i = 1'b0;
    #1;
    chk("mid.post_rvalid", rvalid, 0);
    chk("mid.post_arready", arready, 1);
    arvalid = 1'b0;
    ex[0] = 32'd1;
    do_read(32'h8000_0004, 4'd2, 8'd0, 2'd1, 2'b00, 1'b0, "retain_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

AXI4 slave-side memory that answers the instruction- and data-cache AXI masters of the core: it accepts read and write bursts, stores 32-bit words in an internal single-port RAM, and returns R/B responses. It is the responder end of the cache AXI ports. It is used as boot/working RAM in SoC builds and as the memory model in core-level simulation. It serves one transaction at a time and is fully synchronous.

## Interface
Parameters:
- MEM_ADDR_W, 14: word-address width; the RAM holds 2^MEM_ADDR_W 32-bit words (64 KB by default).
- BASE_ADDR, 32'h80000000: decode base. A hit is `addr[31:MEM_ADDR_W+2] == BASE_ADDR[31:MEM_ADDR_W+2]`.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- axi_awvalid_i / axi_awready_o  in/out  1  AW handshake.
- axi_awaddr_i  in  32  write address. Bits [1:0] are ignored.
- axi_awid_i  in  4  write ID.
- axi_awlen_i  in  8  write burst length; beats = awlen+1.
- axi_awburst_i  in  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 treated as INCR.
- axi_wvalid_i / axi_wready_o  in/out  1  W handshake.
- axi_wdata_i  in  32  write data.
- axi_wstrb_i  in  4  byte enables.
- axi_wlast_i  in  1  last write beat.
- axi_bvalid_o / axi_bready_i  out/in  1  B handshake.
- axi_bresp_o  out  2  write response.
- axi_bid_o  out  4  write response ID.
- axi_arvalid_i / axi_arready_o  in/out  1  AR handshake.
- axi_araddr_i  in  32  read address.
- axi_arid_i  in  4  read ID.
- axi_arlen_i  in  8  read burst length.
- axi_arburst_i  in  2  read burst type.
- axi_rvalid_o / axi_rready_i  out/in  1  R handshake.
- axi_rdata_o  out  32  read data.
- axi_rresp_o  out  2  read response.
- axi_rid_o  out  4  read ID.
- axi_rlast_o  out  1  last read beat.

## Operation
State machine: IDLE, WRITE, WRESP, READ.
- **IDLE:** axi_awready_o and axi_arready_o are combinational grants.
  - AR is granted when arvalid && (!awvalid || prio_rd).
  - AW is granted when awvalid && (!arvalid || !prio_rd).
  - prio_rd toggles after every granted transaction. prio_rd=1 after reset.
- **On an AW grant:** capture addr[MEM_ADDR_W+1:2], id, len and burst; latch hit/miss; clear beat_cnt; go to WRITE.
- **WRITE:** axi_wready_o=1.
  - Each W handshake writes the bytes selected by wstrb to mem[idx], but only on a hit. Misses drop the data.
  - Each W handshake then advances idx and beat_cnt.
  - The beat with beat_cnt==len ends the burst, whatever wlast says; go to WRESP.
  - A wlast value that disagrees with beat_cnt==len on any beat sets a sticky err flag.
- **WRESP:** bvalid=1, bid = captured id.
  - bresp = 2'b11 (DECERR) on a miss, else 2'b10 (SLVERR) if err is set, else 2'b00.
  - On bready, go to IDLE.
- **On an AR grant:** read mem[araddr index] in the same cycle; capture fields; go to READ.
- **READ:** rvalid=1, rid = captured id, rlast = (beat_cnt==len).
  - rresp = 2'b11 on a miss, with rdata = 0; else 2'b00.
  - On each R handshake that is not the last beat, advance idx and read mem[next idx] into the rdata register.
  - On the last-beat handshake, go to IDLE.
- **Address advance** (word index, modulo 2^MEM_ADDR_W):
  - FIXED: index unchanged.
  - INCR: index + 1.
  - WRAP: allowed only with len ∈ {1,3,7,15}; mask = len. New index = (idx & ~mask) | ((idx+1) & mask). WRAP with any other len behaves as INCR.
- Hit/miss is decided once, in the address phase. An in-range burst that runs past the top of the RAM wraps modulo the RAM size.

## Timing
- While rst_i=1, all outputs are 0, including the readies. State goes to IDLE, prio_rd=1, err=0. RAM contents are retained.
- A reset asserted mid-burst abandons the transaction. No B or R response is issued for it.
- Write burst of N beats:
  - AW handshake at cycle T; wready from T+1.
  - With wvalid held high, the last beat lands at T+N. bvalid is asserted at T+N+1.
  - The next grant is possible in the cycle after the B handshake.
- Read burst:
  - AR handshake at T; first rvalid at T+1.
  - With rready held high, one beat per cycle; the last beat is at T+N.
  - The next grant is possible at T+N+1.
- rvalid, rdata, rresp, rid and rlast are registered and stay stable while rready=0. bvalid and bresp stay stable while bready=0.
- awready/arready are 0 outside IDLE. Simultaneous AW and AR in IDLE follow the prio_rd rule.

## Test plan
- **INCR write then read:** AW addr 0x80000010, len 3, INCR, data 0x11..0x44, wstrb 0xF. Required: bresp 0, bvalid at T+5. Then AR with the same address: rdata 0x11,0x22,0x33,0x44 at T+1..T+4, rlast on the 4th beat only.
- **Byte strobes:** write 0xAABBCCDD with wstrb 0x5 over 0x00000000. Required: read-back 0x00BB00DD.
- **WRAP:** AR addr 0x80000018, len 3, WRAP, over words holding their own index. Required: beats from word indices 6,7,4,5.
- **Decode miss:** AW 0x00001000, len 0. Required: bresp 2'b11 and the RAM is unchanged. AR 0x00001000. Required: rdata 0, rresp 2'b11.
- **wlast mismatch:** len 1 with wlast on beat 0 only. Required: 2 beats written, bresp 2'b10.
- **Arbitration, backpressure and reset:**
  - AW and AR asserted together right after reset. Required: AR granted first, then AW.
  - rready toggling. Required: rdata held while rready=0.
  - rst_i pulsed mid-read. Required: rvalid=0 the next cycle and readies return after rst_i deasserts.
